// File: rtl/enc8b10b_pkg.sv
// Shared 8b/10b definitions: disparity constants, RD- sub-block code tables,
// the legal K-character list and the x.A7 trigger sets.
package enc8b10b_pkg;

  localparam logic RD_NEG = 1'b0;
  localparam logic RD_POS = 1'b1;

  // abcdei for D.0..D.31 at RD-; RD+ forms are derived in the lane encoder.
  localparam logic [5:0] CODE6_NEG [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011
  };

  // fghj for D.x.0..D.x.P7 at RD-.
  localparam logic [3:0] CODE4_NEG [8] = '{
    4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110
  };

  localparam logic [5:0] K28_6B_NEG   = 6'b001111;
  localparam logic [3:0] CODE4_A7_NEG = 4'b0111;

  function automatic logic is_legal_k(input logic [7:0] b);
    return (b[4:0] == 5'd28) ||
           ((b[7:5] == 3'd7) && ((b[4:0] == 5'd23) || (b[4:0] == 5'd27) ||
                                 (b[4:0] == 5'd29) || (b[4:0] == 5'd30)));
  endfunction

  function automatic logic a7_at_neg(input logic [4:0] x);
    return (x == 5'd17) || (x == 5'd18) || (x == 5'd20);
  endfunction

  function automatic logic a7_at_pos(input logic [4:0] x);
    return (x == 5'd11) || (x == 5'd13) || (x == 5'd14);
  endfunction

  function automatic logic balanced6(input logic [5:0] v);
    return $countones(v) == 3;
  endfunction

  function automatic logic balanced4(input logic [3:0] v);
    return $countones(v) == 2;
  endfunction

endpackage

// File: rtl/enc8b10b_lane.sv
// Combinational single-byte 8b/10b encoder stage; running disparity in, out.
// Illegal K requests fall back to the D code of the same byte and flag k_err.
module enc8b10b_lane
  import enc8b10b_pkg::*;
(
  input  logic [7:0] data,
  input  logic       k,
  input  logic       rd_in,
  output logic [9:0] code,
  output logic       rd_next,
  output logic       k_err
);

  logic [4:0] x;
  logic [2:0] y;
  logic       k_ok;
  logic       k28;
  logic       rd6;
  logic [5:0] six_neg;
  logic [5:0] six;
  logic [3:0] four_neg;
  logic [3:0] four;

  assign x     = data[4:0];
  assign y     = data[7:5];
  assign k_ok  = k && is_legal_k(data);
  assign k_err = k && !k_ok;
  assign k28   = k_ok && (x == 5'd28);

  always_comb begin
    six_neg = k28 ? K28_6B_NEG : CODE6_NEG[x];
    // D.7 is balanced yet still has a distinct RD+ form.
    six = ((rd_in == RD_POS) && (!balanced6(six_neg) || (x == 5'd7))) ? ~six_neg : six_neg;
    rd6 = balanced6(six_neg) ? rd_in : ~rd_in;

    if ((y == 3'd7) && (k_ok || ((rd6 == RD_NEG) && a7_at_neg(x)) ||
                        ((rd6 == RD_POS) && a7_at_pos(x))))
      four_neg = CODE4_A7_NEG;
    else
      four_neg = CODE4_NEG[y];

    // K28.1/.2/.5/.6 invert the balanced 4b code when the 6b block left RD-.
    if (k28 && (y inside {3'd1, 3'd2, 3'd5, 3'd6}))
      four = (rd6 == RD_POS) ? four_neg : ~four_neg;
    else
      four = ((rd6 == RD_POS) && (!balanced4(four_neg) || (y == 3'd3))) ? ~four_neg : four_neg;

    rd_next = balanced4(four_neg) ? rd6 : ~rd6;
    code    = {six, four};
  end

endmodule

// File: rtl/enc8b10b_multi.sv
// Multi-lane 8b/10b encoder with registered output and RD chained across lanes/beats.
// Optional ENC8B10B_RD_FORCE_EN adds rd_force/rd_force_val to override lane 0's RD.
module enc8b10b_multi
  import enc8b10b_pkg::*;
#(
  parameter int LANES        = 2,
  parameter int OUT_REG_SKID = 0
) (
  input  logic                  BYTECLK,
  input  logic                  RESET_N,
  input  logic [8*LANES-1:0]    data_in,
  input  logic [LANES-1:0]      k_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [10*LANES-1:0]   data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES-1:0]      code_err,
  output logic                  rd_out
`ifdef ENC8B10B_RD_FORCE_EN
  ,
  input  logic                  rd_force,
  input  logic                  rd_force_val
`endif
);

  logic                  rd_reg;
  logic [LANES:0]        rd_chain;
  logic [10*LANES-1:0]   enc_code;
  logic [LANES-1:0]      enc_err;
  logic                  valid_reg;
  logic [10*LANES-1:0]   data_reg;
  logic [LANES-1:0]      err_reg;
  logic                  rdo_reg;
  logic                  accept;

`ifdef ENC8B10B_RD_FORCE_EN
  assign rd_chain[0] = rd_force ? rd_force_val : rd_reg;
`else
  assign rd_chain[0] = rd_reg;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      enc8b10b_lane u_lane (
        .data    (data_in[8*gi +: 8]),
        .k       (k_in[gi]),
        .rd_in   (rd_chain[gi]),
        .code    (enc_code[10*gi +: 10]),
        .rd_next (rd_chain[gi+1]),
        .k_err   (enc_err[gi])
      );
    end
  endgenerate

  assign accept = in_valid && in_ready;

  always_ff @(posedge BYTECLK or negedge RESET_N) begin
    if (!RESET_N)
      rd_reg <= RD_NEG;
    else if (accept)
      rd_reg <= rd_chain[LANES];
  end

  generate
    if (OUT_REG_SKID == 0) begin : g_direct
      assign in_ready = !valid_reg || out_ready;

      always_ff @(posedge BYTECLK or negedge RESET_N) begin
        if (!RESET_N) begin
          valid_reg <= 1'b0;
          data_reg  <= '0;
          err_reg   <= '0;
          rdo_reg   <= RD_NEG;
        end else if (in_ready) begin
          valid_reg <= in_valid;
          if (in_valid) begin
            data_reg <= enc_code;
            err_reg  <= enc_err;
            rdo_reg  <= rd_chain[LANES];
          end
        end
      end
    end else begin : g_skid
      logic                skid_valid_reg;
      logic [10*LANES-1:0] skid_data_reg;
      logic [LANES-1:0]    skid_err_reg;
      logic                skid_rd_reg;

      // in_ready only looks at registered state, breaking the out_ready path.
      assign in_ready = !skid_valid_reg;

      always_ff @(posedge BYTECLK or negedge RESET_N) begin
        if (!RESET_N) begin
          valid_reg      <= 1'b0;
          data_reg       <= '0;
          err_reg        <= '0;
          rdo_reg        <= RD_NEG;
          skid_valid_reg <= 1'b0;
          skid_data_reg  <= '0;
          skid_err_reg   <= '0;
          skid_rd_reg    <= RD_NEG;
        end else if (!valid_reg || out_ready) begin
          if (skid_valid_reg) begin
            valid_reg      <= 1'b1;
            data_reg       <= skid_data_reg;
            err_reg        <= skid_err_reg;
            rdo_reg        <= skid_rd_reg;
            skid_valid_reg <= 1'b0;
          end else begin
            valid_reg <= in_valid;
            if (in_valid) begin
              data_reg <= enc_code;
              err_reg  <= enc_err;
              rdo_reg  <= rd_chain[LANES];
            end
          end
        end else if (accept) begin
          skid_valid_reg <= 1'b1;
          skid_data_reg  <= enc_code;
          skid_err_reg   <= enc_err;
          skid_rd_reg    <= rd_chain[LANES];
        end
      end
    end
  endgenerate

  assign out_valid = valid_reg;
  assign data_out  = data_reg;
  assign code_err  = err_reg;
  assign rd_out    = rdo_reg;

endmodule

// File: tb/tb_enc8b10b_multi.sv
// Bench for enc8b10b_multi: directed scenarios on a 2-lane direct-output instance
// plus a random stream on a 4-lane skid instance, checked against a table model.
module tb_enc8b10b_multi;

  localparam int LA = 2;
  localparam int LB = 4;

  typedef struct {
    logic [39:0] code;
    logic [3:0]  err;
    logic        rd;
  } exp_t;

  // Full RD-/RD+ columns of the standard tables; RD tracked from code weight.
  localparam logic [5:0] T6N [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [5:0] T6P [32] = '{
    6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
    6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
    6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
    6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
  localparam logic [3:0] T4N [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  localparam logic [3:0] T4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
  localparam logic [3:0] K4N [8] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
  localparam logic [3:0] K4P [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
  localparam logic [7:0] KLIST [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
                                        8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

  logic BYTECLK;
  logic RESET_N;

  logic [8*LA-1:0]  data_in_a;
  logic [LA-1:0]    k_in_a;
  logic             in_valid_a, in_ready_a, out_valid_a, out_ready_a, rd_out_a;
  logic [10*LA-1:0] data_out_a;
  logic [LA-1:0]    code_err_a;

  logic [8*LB-1:0]  data_in_b;
  logic [LB-1:0]    k_in_b;
  logic             in_valid_b, in_ready_b, out_valid_b, out_ready_b, rd_out_b;
  logic [10*LB-1:0] data_out_b;
  logic [LB-1:0]    code_err_b;

`ifdef ENC8B10B_RD_FORCE_EN
  logic rd_force_a, rd_force_val_a, rd_force_b, rd_force_val_b;
`endif

  int   checks;
  int   errors;
  exp_t q_a [$];
  exp_t q_b [$];
  logic mrd_a, mrd_b;

  enc8b10b_multi #(.LANES(LA), .OUT_REG_SKID(0)) dut_a (
    .BYTECLK   (BYTECLK),
    .RESET_N   (RESET_N),
    .data_in   (data_in_a),
    .k_in      (k_in_a),
    .in_valid  (in_valid_a),
    .in_ready  (in_ready_a),
    .data_out  (data_out_a),
    .out_valid (out_valid_a),
    .out_ready (out_ready_a),
    .code_err  (code_err_a),
    .rd_out    (rd_out_a)
`ifdef ENC8B10B_RD_FORCE_EN
    ,
    .rd_force     (rd_force_a),
    .rd_force_val (rd_force_val_a)
`endif
  );

  enc8b10b_multi #(.LANES(LB), .OUT_REG_SKID(1)) dut_b (
    .BYTECLK   (BYTECLK),
    .RESET_N   (RESET_N),
    .data_in   (data_in_b),
    .k_in      (k_in_b),
    .in_valid  (in_valid_b),
    .in_ready  (in_ready_b),
    .data_out  (data_out_b),
    .out_valid (out_valid_b),
    .out_ready (out_ready_b),
    .code_err  (code_err_b),
    .rd_out    (rd_out_b)
`ifdef ENC8B10B_RD_FORCE_EN
    ,
    .rd_force     (rd_force_b),
    .rd_force_val (rd_force_val_b)
`endif
  );

  initial BYTECLK = 1'b0;
  always #5 BYTECLK = ~BYTECLK;

  task automatic enc_byte(input logic [7:0] b, input logic k, input logic rd,
                          output logic [9:0] c, output logic rn, output logic er);
    int x, y;
    logic legal, r6;
    logic [5:0] s;
    logic [3:0] f;
    x = int'(b[4:0]);
    y = int'(b[7:5]);
    legal = (x == 28) || (y == 7 && (x == 23 || x == 27 || x == 29 || x == 30));
    er = k && !legal;
    if (k && legal && x == 28) s = rd ? 6'b110000 : 6'b001111;
    else                       s = rd ? T6P[x] : T6N[x];
    r6 = ($countones(s) > 3) ? 1'b1 : ($countones(s) < 3) ? 1'b0 : rd;
    if (k && legal && x == 28)
      f = r6 ? K4P[y] : K4N[y];
    else if (y == 7 && ((k && legal) || (!r6 && (x == 17 || x == 18 || x == 20)) ||
                        (r6 && (x == 11 || x == 13 || x == 14))))
      f = r6 ? 4'b1000 : 4'b0111;
    else
      f = r6 ? T4P[y] : T4N[y];
    rn = ($countones(f) > 2) ? 1'b1 : ($countones(f) < 2) ? 1'b0 : r6;
    c = {s, f};
  endtask

  task automatic model_beat(input logic [31:0] d, input logic [3:0] k, input int lanes,
                            inout logic rd, output exp_t e);
    logic [9:0] c;
    logic rn, er;
    e.code = '0;
    e.err  = '0;
    for (int l = 0; l < lanes; l++) begin
      enc_byte(d[8*l +: 8], k[l], rd, c, rn, er);
      e.code[10*l +: 10] = c;
      e.err[l] = er;
      rd = rn;
    end
    e.rd = rd;
  endtask

  // One clock: scoreboard sampling at the falling edge, then return 1 ns past the rising edge.
  task automatic step();
    exp_t e;
    @(negedge BYTECLK);
    if (!RESET_N) begin
      q_a.delete();
      q_b.delete();
      mrd_a = 1'b0;
      mrd_b = 1'b0;
    end else begin
      if (out_valid_a && out_ready_a) begin
        checks++;
        if (q_a.size() == 0) begin
          errors++;
          $display("FAIL sb_a_extra: got data_out=%b with no beat outstanding", data_out_a);
        end else begin
          e = q_a.pop_front();
          if ({rd_out_a, code_err_a, data_out_a} !== {e.rd, e.err[LA-1:0], e.code[10*LA-1:0]}) begin
            errors++;
            $display("FAIL sb_a: got data=%b err=%b rd=%b, want data=%b err=%b rd=%b",
                     data_out_a, code_err_a, rd_out_a, e.code[10*LA-1:0], e.err[LA-1:0], e.rd);
          end
        end
      end
      if (out_valid_b && out_ready_b) begin
        checks++;
        if (q_b.size() == 0) begin
          errors++;
          $display("FAIL sb_b_extra: got data_out=%b with no beat outstanding", data_out_b);
        end else begin
          e = q_b.pop_front();
          if ({rd_out_b, code_err_b, data_out_b} !== {e.rd, e.err, e.code}) begin
            errors++;
            $display("FAIL sb_b: got data=%b err=%b rd=%b, want data=%b err=%b rd=%b",
                     data_out_b, code_err_b, rd_out_b, e.code, e.err, e.rd);
          end
        end
      end
      if (in_valid_a && in_ready_a) begin
        model_beat({16'h0, data_in_a}, {2'b00, k_in_a}, LA, mrd_a, e);
        q_a.push_back(e);
      end
      if (in_valid_b && in_ready_b) begin
        model_beat(data_in_b, k_in_b, LB, mrd_b, e);
        q_b.push_back(e);
      end
    end
    @(posedge BYTECLK);
    #1;
  endtask

  task automatic pick_lane(output logic [7:0] b, output logic k);
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 3) begin
      k = 1'b1;
      b = KLIST[$urandom_range(0, 11)];
    end else begin
      k = (r == 3);
      b = 8'($urandom);
    end
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    repeat (3) step();
    checks += 7;
    if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid_a); end
    if (data_out_a !== '0) begin errors++; $display("FAIL reset_data_out: got %b want 0", data_out_a); end
    if (code_err_a !== '0) begin errors++; $display("FAIL reset_code_err: got %b want 0", code_err_a); end
    if (rd_out_a !== 1'b0) begin errors++; $display("FAIL reset_rd_out: got %b want 0", rd_out_a); end
    if (in_ready_a !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready_a); end
    if (out_valid_b !== 1'b0) begin errors++; $display("FAIL reset_out_valid_b: got %b want 0", out_valid_b); end
    if (in_ready_b !== 1'b1) begin errors++; $display("FAIL reset_in_ready_b: got %b want 1", in_ready_b); end
    RESET_N = 1'b1;
    step();
    $display("test_reset: done");
  endtask

  task automatic test_d21_5();
    data_in_a = {8'hB5, 8'hB5}; k_in_a = 2'b00; in_valid_a = 1'b1;
    step();
    in_valid_a = 1'b0;
    checks += 3;
    if (out_valid_a !== 1'b1) begin errors++; $display("FAIL d21_5_latency: out_valid got %b want 1", out_valid_a); end
    if (data_out_a !== {10'b1010101010, 10'b1010101010}) begin errors++; $display("FAIL d21_5_code: got %b want 10101010101010101010", data_out_a); end
    if (rd_out_a !== 1'b0) begin errors++; $display("FAIL d21_5_rd: got %b want 0", rd_out_a); end
    step();
    checks++;
    if (out_valid_a !== 1'b0) begin errors++; $display("FAIL d21_5_drain: out_valid got %b want 0", out_valid_a); end
    $display("test_d21_5: data_out=%b rd_out=%b", data_out_a, rd_out_a);
  endtask

  task automatic test_k28_5();
    data_in_a = {8'hB5, 8'hBC}; k_in_a = 2'b01; in_valid_a = 1'b1;
    step();
    checks += 3;
    if (data_out_a[9:0] !== 10'b0011111010) begin errors++; $display("FAIL k28_5_first: got %b want 0011111010", data_out_a[9:0]); end
    if (rd_out_a !== 1'b1) begin errors++; $display("FAIL k28_5_first_rd: got %b want 1", rd_out_a); end
    if (code_err_a !== 2'b00) begin errors++; $display("FAIL k28_5_err: got %b want 00", code_err_a); end
    step();
    in_valid_a = 1'b0;
    checks += 2;
    if (data_out_a[9:0] !== 10'b1100000101) begin errors++; $display("FAIL k28_5_second: got %b want 1100000101", data_out_a[9:0]); end
    if (rd_out_a !== 1'b0) begin errors++; $display("FAIL k28_5_second_rd: got %b want 0", rd_out_a); end
    step();
    $display("test_k28_5: done");
  endtask

  task automatic test_d0_0();
    data_in_a = 16'h0000; k_in_a = 2'b00; in_valid_a = 1'b1;
    step();
    in_valid_a = 1'b0;
    checks += 2;
    if (data_out_a !== {10'b1001110100, 10'b1001110100}) begin errors++; $display("FAIL d0_0_chain: got %b want 10011101001001110100", data_out_a); end
    if (rd_out_a !== 1'b0) begin errors++; $display("FAIL d0_0_rd: got %b want 0", rd_out_a); end
    step();
    $display("test_d0_0: done");
  endtask

  task automatic test_stall();
    out_ready_a = 1'b0;
    data_in_a = {8'h00, 8'hBC}; k_in_a = 2'b01; in_valid_a = 1'b1;
    step();
    data_in_a = {8'h00, 8'hBC}; k_in_a = 2'b01;
    for (int i = 0; i < 3; i++) begin
      checks += 3;
      if (in_ready_a !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready_a); end
      if (data_out_a !== {10'b0110001011, 10'b0011111010}) begin errors++; $display("FAIL stall_hold[%0d]: got %b want 01100010110011111010", i, data_out_a); end
      if (rd_out_a !== 1'b1) begin errors++; $display("FAIL stall_rd[%0d]: got %b want 1", i, rd_out_a); end
      step();
    end
    out_ready_a = 1'b1;
    #1;
    checks++;
    if (in_ready_a !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b want 1", in_ready_a); end
    step();
    in_valid_a = 1'b0;
    checks += 3;
    if (out_valid_a !== 1'b1) begin errors++; $display("FAIL stall_replace_valid: got %b want 1", out_valid_a); end
    if (data_out_a !== {10'b1001110100, 10'b1100000101}) begin errors++; $display("FAIL stall_replace: got %b want 10011101001100000101", data_out_a); end
    if (rd_out_a !== 1'b0) begin errors++; $display("FAIL stall_replace_rd: got %b want 0", rd_out_a); end
    step();
    checks++;
    if (q_a.size() != 0 || out_valid_a !== 1'b0) begin errors++; $display("FAIL stall_no_loss: queue=%0d out_valid=%b want 0,0", q_a.size(), out_valid_a); end
    $display("test_stall: done");
  endtask

  task automatic test_code_err();
    data_in_a = {8'hBC, 8'h00}; k_in_a = 2'b11; in_valid_a = 1'b1;
    step();
    checks += 3;
    if (code_err_a !== 2'b01) begin errors++; $display("FAIL code_err_flag: got %b want 01", code_err_a); end
    if (data_out_a !== {10'b0011111010, 10'b1001110100}) begin errors++; $display("FAIL code_err_neg: got %b want 00111110101001110100", data_out_a); end
    if (rd_out_a !== 1'b1) begin errors++; $display("FAIL code_err_rd: got %b want 1", rd_out_a); end
    step();
    in_valid_a = 1'b0;
    checks += 2;
    if (data_out_a !== {10'b1100000101, 10'b0110001011}) begin errors++; $display("FAIL code_err_pos: got %b want 11000001010110001011", data_out_a); end
    if (code_err_a !== 2'b01) begin errors++; $display("FAIL code_err_flag2: got %b want 01", code_err_a); end
    step();
    $display("test_code_err: done");
  endtask

  task automatic test_reset_mid();
    out_ready_a = 1'b0;
    data_in_a = {8'hB5, 8'hBC}; k_in_a = 2'b01; in_valid_a = 1'b1;
    step();
    in_valid_a = 1'b0;
    checks += 2;
    if (out_valid_a !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b want 1", out_valid_a); end
    if (rd_out_a !== 1'b1) begin errors++; $display("FAIL mid_pre_rd: got %b want 1", rd_out_a); end
    RESET_N = 1'b0;
    #1;
    checks += 2;
    if (out_valid_a !== 1'b0) begin errors++; $display("FAIL mid_async_valid: got %b want 0", out_valid_a); end
    if (rd_out_a !== 1'b0) begin errors++; $display("FAIL mid_async_rd: got %b want 0", rd_out_a); end
    step();
    RESET_N = 1'b1;
    out_ready_a = 1'b1;
    step();
    data_in_a = 16'h0000; k_in_a = 2'b00; in_valid_a = 1'b1;
    step();
    in_valid_a = 1'b0;
    checks++;
    if (data_out_a[9:0] !== 10'b1001110100) begin errors++; $display("FAIL mid_after_reset: got %b want 1001110100", data_out_a[9:0]); end
    step();
    $display("test_reset_mid: done");
  endtask

  task automatic test_back_to_back();
    logic [7:0] bb;
    logic kk;
    int n_a;
    n_a = 0;
    for (int i = 0; i < 300; i++) begin
      for (int l = 0; l < LA; l++) begin
        pick_lane(bb, kk);
        data_in_a[8*l +: 8] = bb;
        k_in_a[l] = kk;
      end
      for (int l = 0; l < LB; l++) begin
        pick_lane(bb, kk);
        data_in_b[8*l +: 8] = bb;
        k_in_b[l] = kk;
      end
      if (i < 20) begin
        in_valid_a = 1'b1;
        out_ready_a = 1'b1;
      end else begin
        in_valid_a = ($urandom_range(0, 3) != 0);
        out_ready_a = ($urandom_range(0, 3) != 0);
      end
      in_valid_b = ($urandom_range(0, 3) != 0);
      out_ready_b = ($urandom_range(0, 2) != 0);
      #1;
      if (i < 20) begin
        checks++;
        if (in_ready_a !== 1'b1) begin errors++; $display("FAIL throughput_ready[%0d]: got %b want 1", i, in_ready_a); end
      end
      if (in_valid_a && in_ready_a) n_a++;
      step();
    end
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    out_ready_a = 1'b1; out_ready_b = 1'b1;
    for (int i = 0; i < 20 && (q_a.size() != 0 || q_b.size() != 0); i++) step();
    step();
    checks++;
    if (q_a.size() != 0 || q_b.size() != 0 || out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin
      errors++;
      $display("FAIL drain: q_a=%0d q_b=%0d out_valid_a=%b out_valid_b=%b want all 0",
               q_a.size(), q_b.size(), out_valid_a, out_valid_b);
    end
    $display("test_back_to_back: %0d beats accepted on 2-lane instance", n_a);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mrd_a = 1'b0;
    mrd_b = 1'b0;
    RESET_N = 1'b0;
    data_in_a = '0; k_in_a = '0; in_valid_a = 1'b0; out_ready_a = 1'b1;
    data_in_b = '0; k_in_b = '0; in_valid_b = 1'b0; out_ready_b = 1'b1;
`ifdef ENC8B10B_RD_FORCE_EN
    rd_force_a = 1'b0; rd_force_val_a = 1'b0;
    rd_force_b = 1'b0; rd_force_val_b = 1'b0;
`endif
    test_reset();
    test_d21_5();
    test_k28_5();
    test_d0_0();
    test_stall();
    test_code_err();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
